cdda_i2s_tx: RTL

Audio output stage for the CD-DA path. Accepts stereo 16-bit PCM frames through a small FIFO and serialises them as standard I2S (64 BCK per frame, 32-bit slots, MSB-first, one-BCK delay after LRCK edge) on the SCK/LRCK/SDAT pins toward the external DAC. It runs in the fast system clock domain (CPU_FREQ*4) and derives BCK by integer division. Underrun and overflow are reported as sticky flags for the AVR firmware.

---
 rtl/cdda_i2s_tx.sv | 115 +++++++++++
 1 files changed

// File: rtl/cdda_i2s_tx.sv
// CD-DA audio output: stereo frame FIFO feeding a 64-BCK I2S serialiser.
// BCK is derived from the system clock; underrun/overflow are sticky flags.
module cdda_i2s_tx #(
  parameter int CLK_FREQUENCY = 67737600,
  parameter int SAMPLE_RATE   = 44100,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        enable,
  input  logic [15:0]                 wr_left,
  input  logic [15:0]                 wr_right,
  input  logic                        wr_strobe,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  output logic                        overflow,
  input  logic                        flag_clr,
  output logic                        bck,
  output logic                        lrck,
  output logic                        sd
);

  localparam int HALF_DIV = CLK_FREQUENCY / (SAMPLE_RATE * 128);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int DW       = $clog2(HALF_DIV);
  localparam logic [DW-1:0] DIV_MAX  = DW'(HALF_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = FIFO_DEPTH[AW:0];

  if (HALF_DIV < 2 || HALF_DIV * SAMPLE_RATE * 128 != CLK_FREQUENCY) begin : g_bad_div
    $error("cdda_i2s_tx: CLK_FREQUENCY must be an exact multiple >=2 of SAMPLE_RATE*128");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdda_i2s_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] div;
  logic          run;
  logic [5:0]    bit_cnt, nb;
  logic [31:0]   frame;
  logic          wrap, fall, pop, push, empty, lrck_n, sd_n;

  always_comb begin
    wrap   = enable && run && (div == DIV_MAX);
    fall   = wrap && bck;
    nb     = bit_cnt + 6'd1;
    pop    = fall && (nb == 6'd63);
    empty  = (level == '0);
    push   = wr_strobe && !full;
    lrck_n = (nb >= 6'd31) && (nb != 6'd63);
    // bits 0..15 -> frame[31..16] (left), bits 32..47 -> frame[15..0] (right)
    sd_n   = !nb[4] && frame[{~nb[5], ~nb[3:0]}];
  end

  assign full = (level == LVL_FULL);

  // run delays the divider by one clk so the first BCK rise lands HALF_DIV clks after enable
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run <= 1'b0; div <= '0; bit_cnt <= 6'd62; bck <= 1'b0; lrck <= 1'b0; sd <= 1'b0;
    end else if (!enable) begin
      run <= 1'b0; div <= '0; bit_cnt <= 6'd62; bck <= 1'b0; lrck <= 1'b0; sd <= 1'b0;
    end else if (!run) begin
      run <= 1'b1;
    end else if (wrap) begin
      div <= '0;
      bck <= ~bck;
      if (bck) begin
        bit_cnt <= nb;
        lrck    <= lrck_n;
        sd      <= sd_n;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)    frame <= '0;
    else if (pop) frame <= empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_left, wr_right};
  end

  // a write into an empty FIFO cannot satisfy a pop in the same cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0; rd_ptr <= '0; level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop && !empty})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      underrun <= 1'b0; overflow <= 1'b0;
    end else if (flag_clr) begin
      underrun <= 1'b0; overflow <= 1'b0;
    end else begin
      if (pop && empty)      underrun <= 1'b1;
      if (wr_strobe && full) overflow <= 1'b1;
    end
  end

endmodule
